// File: rtl/sprite_motion_gen.sv
// sprite_motion_gen: per-frame fixed-point motion generator for one sprite's
// top-left corner. Supports bounce, wrap and stop edge modes, pause, sticky
// X/Y speed toggles, gravity on Y with speed saturation, and edge-hit pulses.
// Optional build macro SPRITE_MOTION_FRICTION_EN adds a slow decay of |vx|
// every eighth running frame.
module sprite_motion_gen #(
  parameter int FRAC_BITS       = 6,
  parameter int POS_W           = 24,
  parameter int FRAME_W         = 640,
  parameter int FRAME_H         = 480,
  parameter int SPRITE_W        = 64,
  parameter int SPRITE_H        = 64,
  parameter int INITIAL_X       = 40,
  parameter int INITIAL_Y       = 100,
  parameter int INITIAL_X_SPEED = 50,
  parameter int INITIAL_Y_SPEED = 0,
  parameter int Y_ACCEL         = 1,
  parameter int MAX_SPEED       = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start,
  input  logic        pause,
  input  logic        toggleX,
  input  logic        toggleY,
  input  logic [1:0]  edgeMode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        moving,
  output logic [3:0]  hitEdge
);

  localparam int MAXX_I = (FRAME_W - SPRITE_W) << FRAC_BITS;
  localparam int MAXY_I = (FRAME_H - SPRITE_H) << FRAC_BITS;
  localparam int SPANX_I = MAXX_I + (1 << FRAC_BITS);
  localparam int SPANY_I = MAXY_I + (1 << FRAC_BITS);
  localparam int INITX_I = INITIAL_X << FRAC_BITS;
  localparam int INITY_I = INITIAL_Y << FRAC_BITS;

  localparam logic signed [POS_W-1:0] MAX_X   = MAXX_I[POS_W-1:0];
  localparam logic signed [POS_W-1:0] MAX_Y   = MAXY_I[POS_W-1:0];
  localparam logic signed [POS_W-1:0] SPAN_X  = SPANX_I[POS_W-1:0];
  localparam logic signed [POS_W-1:0] SPAN_Y  = SPANY_I[POS_W-1:0];
  localparam logic signed [POS_W-1:0] INIT_PX = INITX_I[POS_W-1:0];
  localparam logic signed [POS_W-1:0] INIT_PY = INITY_I[POS_W-1:0];
  localparam logic signed [POS_W-1:0] INIT_VX = INITIAL_X_SPEED[POS_W-1:0];
  localparam logic signed [POS_W-1:0] INIT_VY = INITIAL_Y_SPEED[POS_W-1:0];
  localparam logic signed [POS_W-1:0] ACCEL   = Y_ACCEL[POS_W-1:0];
  localparam logic signed [POS_W-1:0] VMAX    = MAX_SPEED[POS_W-1:0];

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t state;
  logic signed [POS_W-1:0] pos_x, pos_y, vel_x, vel_y;
  logic start_d, toggle_x_d, toggle_y_d;
  logic pend_x, pend_y;

  logic start_rise, pend_x_now, pend_y_now, step_en;
  logic signed [POS_W-1:0] vx_f, vy_acc, vx1, vy1, nx, ny;
  logic signed [POS_W-1:0] px_n, py_n, vx_n, vy_n;
  logic lo_x, hi_x, lo_y, hi_y;

  // Resolve one axis against [0, lim] according to the edge mode.
  function automatic void edge_axis(
    input  logic [1:0]              mode,
    input  logic signed [POS_W-1:0] n,
    input  logic signed [POS_W-1:0] v,
    input  logic signed [POS_W-1:0] lim,
    input  logic signed [POS_W-1:0] span,
    output logic signed [POS_W-1:0] p,
    output logic signed [POS_W-1:0] vo,
    output logic                    lo,
    output logic                    hi
  );
    lo = n[POS_W-1];
    hi = n > lim;
    p  = n;
    vo = v;
    case (mode)
      2'd1: begin
        if (lo)      p = n + span;
        else if (hi) p = n - span;
      end
      2'd2: begin
        if (lo)      begin p = '0;  vo = '0; end
        else if (hi) begin p = lim; vo = '0; end
      end
      default: begin
        if (lo)      begin p = '0;  vo = v[POS_W-1] ? -v : v; end
        else if (hi) begin p = lim; vo = v[POS_W-1] ? v : -v; end
      end
    endcase
  endfunction

  assign start_rise = start & ~start_d;
  assign pend_x_now = pend_x | (toggleX & ~toggle_x_d);
  assign pend_y_now = pend_y | (toggleY & ~toggle_y_d);
  assign step_en    = (state == RUN) && startOfFrame && !start_rise && !pause;

`ifdef SPRITE_MOTION_FRICTION_EN
  localparam logic signed [POS_W-1:0] ONE = 1;
  logic [2:0] frame_cnt;

  // Count running frame steps; the eighth of each group applies friction.
  always_ff @(posedge clk) begin
    if (reset)        frame_cnt <= '0;
    else if (step_en) frame_cnt <= frame_cnt + 3'd1;
  end

  // Shrink |vx| by one on the friction frame, never crossing zero.
  always_comb begin
    vx_f = vel_x;
    if (frame_cnt == 3'd7 && vel_x != '0) begin
      vx_f = vel_x[POS_W-1] ? vel_x + ONE : vel_x - ONE;
    end
  end
`else
  assign vx_f = vel_x;
`endif

  // Candidate next position/speed for a frame step.
  always_comb begin
    // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
    vy_acc = vel_y + ACCEL;
    vy1    = vy_acc;
    if (vy_acc > VMAX)       vy1 = VMAX;
    else if (vy_acc < -VMAX) vy1 = -VMAX;
    vx1 = pend_x_now ? -vx_f : vx_f;
    if (pend_y_now) vy1 = -vy1;
    nx = pos_x + vx1;
    ny = pos_y + vy1;
    edge_axis(edgeMode, nx, vx1, MAX_X, SPAN_X, px_n, vx_n, lo_x, hi_x);
    edge_axis(edgeMode, ny, vy1, MAX_Y, SPAN_Y, py_n, vy_n, lo_y, hi_y);
  end

  // Control FSM together with position, speed, toggle and hit registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state      <= IDLE;
      pos_x      <= INIT_PX;
      pos_y      <= INIT_PY;
      vel_x      <= '0;
      vel_y      <= '0;
      moving     <= 1'b0;
      hitEdge    <= '0;
      start_d    <= 1'b0;
      toggle_x_d <= 1'b0;
      toggle_y_d <= 1'b0;
      pend_x     <= 1'b0;
      pend_y     <= 1'b0;
    end else begin
      start_d    <= start;
      toggle_x_d <= toggleX;
      toggle_y_d <= toggleY;
      hitEdge    <= '0;
      if (start_rise) begin
        state  <= RUN;
        moving <= 1'b1;
        pos_x  <= INIT_PX;
        pos_y  <= INIT_PY;
        vel_x  <= INIT_VX;
        vel_y  <= INIT_VY;
        pend_x <= 1'b0;
        pend_y <= 1'b0;
      end else begin
        pend_x <= pend_x_now;
        pend_y <= pend_y_now;
        case (state)
          RUN: begin
            if (pause) begin
              state  <= PAUSE;
              moving <= 1'b0;
            end else if (startOfFrame) begin
              pos_x   <= px_n;
              pos_y   <= py_n;
              vel_x   <= vx_n;
              vel_y   <= vy_n;
              pend_x  <= 1'b0;
              pend_y  <= 1'b0;
              hitEdge <= {lo_y, hi_y, lo_x, hi_x};
            end
          end
          PAUSE: begin
            if (!pause) begin
              state  <= RUN;
              moving <= 1'b1;
            end
          end
          default: moving <= 1'b0;
        endcase
      end
    end
  end

  assign topLeftX = pos_x[FRAC_BITS +: 11];
  assign topLeftY = pos_y[FRAC_BITS +: 11];

endmodule

// File: tb/tb_sprite_motion_gen.sv
// Self-checking bench for sprite_motion_gen: three instances with different
// start geometry share one stimulus stream; a behavioural frame model pushes
// expected outputs to a scoreboard queue that is drained after each edge.
module tb_sprite_motion_gen;

  localparam int NI   = 3;
  localparam int MAXX = 576 * 64;
  localparam int MAXY = 416 * 64;

  logic clk, reset, startOfFrame, start, pause, toggleX, toggleY;
  logic [1:0]  edgeMode;
  logic [10:0] tlx [NI];
  logic [10:0] tly [NI];
  logic        mv  [NI];
  logic [3:0]  hit [NI];

  sprite_motion_gen u_dut0 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start(start),
    .pause(pause), .toggleX(toggleX), .toggleY(toggleY), .edgeMode(edgeMode),
    .topLeftX(tlx[0]), .topLeftY(tly[0]), .moving(mv[0]), .hitEdge(hit[0]));

  sprite_motion_gen #(.INITIAL_X(570)) u_dut1 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start(start),
    .pause(pause), .toggleX(toggleX), .toggleY(toggleY), .edgeMode(edgeMode),
    .topLeftX(tlx[1]), .topLeftY(tly[1]), .moving(mv[1]), .hitEdge(hit[1]));

  sprite_motion_gen #(.INITIAL_X(0), .INITIAL_X_SPEED(-64), .MAX_SPEED(16)) u_dut2 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start(start),
    .pause(pause), .toggleX(toggleX), .toggleY(toggleY), .edgeMode(edgeMode),
    .topLeftX(tlx[2]), .topLeftY(tly[2]), .moving(mv[2]), .hitEdge(hit[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance configuration seen by the model.
  int init_x [NI] = '{40, 570, 0};
  int init_vx[NI] = '{50, 50, -64};
  int vmax   [NI] = '{512, 512, 16};

  // Model state.
  int  m_px[NI], m_py[NI], m_vx[NI], m_vy[NI];
  logic [3:0] m_hit[NI];
  bit  m_run, m_pendx, m_pendy;
  logic [3:0] seen_hit[NI];

  typedef struct {
    int         inst;
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  h;
    logic        mv;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_axis(input int mode, input int n, input int v1, input int lim,
                                 output int p, output int v, output bit lo, output bit hi);
    int mag;
    lo = n < 0;
    hi = n > lim;
    p = n;
    v = v1;
    mag = (v1 < 0) ? -v1 : v1;
    if (lo || hi) begin
      case (mode)
        1: p = lo ? n + lim + 64 : n - lim - 64;
        2: begin p = lo ? 0 : lim; v = 0; end
        default: begin p = lo ? 0 : lim; v = lo ? mag : -mag; end
      endcase
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NI; i++) begin
      m_px[i] = init_x[i] * 64;
      m_py[i] = 100 * 64;
      m_vx[i] = 0;
      m_vy[i] = 0;
      m_hit[i] = '0;
    end
    m_run = 0; m_pendx = 0; m_pendy = 0;
  endfunction

  function automatic void m_reload();
    for (int i = 0; i < NI; i++) begin
      m_px[i] = init_x[i] * 64;
      m_py[i] = 100 * 64;
      m_vx[i] = init_vx[i];
      m_vy[i] = 0;
      m_hit[i] = '0;
    end
    m_run = 1; m_pendx = 0; m_pendy = 0;
  endfunction

  function automatic void m_step(input int mode);
    int vx1, vy1, px, py, vx, vy;
    bit lx, hx, ly, hy;
    for (int i = 0; i < NI; i++) begin
      vy1 = m_vy[i] + 1;
      if (vy1 > vmax[i]) vy1 = vmax[i];
      if (vy1 < -vmax[i]) vy1 = -vmax[i];
      vx1 = m_vx[i];
      if (m_pendx) vx1 = -vx1;
      if (m_pendy) vy1 = -vy1;
      m_axis(mode, m_px[i] + vx1, vx1, MAXX, px, vx, lx, hx);
      m_axis(mode, m_py[i] + vy1, vy1, MAXY, py, vy, ly, hy);
      m_px[i] = px; m_py[i] = py; m_vx[i] = vx; m_vy[i] = vy;
      m_hit[i] = {ly, hy, lx, hx};
    end
    m_pendx = 0; m_pendy = 0;
  endfunction

  function automatic void push_all(input bit with_hit);
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e.inst = i;
      e.x    = 11'(m_px[i] >> 6);
      e.y    = 11'(m_py[i] >> 6);
      e.h    = with_hit ? m_hit[i] : 4'b0000;
      e.mv   = m_run;
      sb.push_back(e);
    end
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("x%0d", e.inst),   32'(tlx[e.inst]), 32'(e.x));
      check($sformatf("y%0d", e.inst),   32'(tly[e.inst]), 32'(e.y));
      check($sformatf("hit%0d", e.inst), 32'(hit[e.inst]), 32'(e.h));
      check($sformatf("mv%0d", e.inst),  32'(mv[e.inst]),  32'(e.mv));
    end
  endtask

  // One frame pulse; compare the cycle after, then confirm the hit pulse ends.
  task automatic frame();
    startOfFrame = 1'b1;
    if (m_run) m_step(int'(edgeMode));
    else for (int i = 0; i < NI; i++) m_hit[i] = '0;
    push_all(1'b1);
    cycle();
    startOfFrame = 1'b0;
    for (int i = 0; i < NI; i++) seen_hit[i] = hit[i];
    drain();
    cycle();
    for (int i = 0; i < NI; i++) check($sformatf("hit_end%0d", i), 32'(hit[i]), 32'd0);
    cycle();
  endtask

  task automatic start_pulse(input bit with_sof);
    start = 1'b1;
    startOfFrame = with_sof;
    m_reload();
    push_all(1'b0);
    cycle();
    start = 1'b0;
    startOfFrame = 1'b0;
    drain();
    cycle();
  endtask

  task automatic toggle_pulse(input bit is_y);
    if (is_y) begin toggleY = 1'b1; m_pendy = 1; end
    else      begin toggleX = 1'b1; m_pendx = 1; end
    cycle();
    toggleX = 1'b0;
    toggleY = 1'b0;
    cycle();
  endtask

  task automatic set_pause(input bit p);
    pause = p;
    m_run = !p;
    push_all(1'b0);
    cycle();
    drain();
  endtask

  initial begin
    bit got_hit;
    reset = 1'b1; startOfFrame = 1'b0; start = 1'b0; pause = 1'b0;
    toggleX = 1'b0; toggleY = 1'b0; edgeMode = 2'd0;
    m_reset();
    cycle();
    cycle();
    push_all(1'b0);
    drain();
    reset = 1'b0;
    cycle();

    // Frames without start leave everything at the reset state.
    for (int k = 0; k < 5; k++) frame();
    check("idle_x0", 32'(tlx[0]), 32'd40);
    check("idle_y0", 32'(tly[0]), 32'd100);

    // Start, first frame in wrap mode, then bounce for nine more frames.
    start_pulse(1'b0);
    edgeMode = 2'd1;
    frame();
    check("wrap_x2", 32'(tlx[2]), 32'd576);
    check("wrap_left2", 32'(seen_hit[2]), 32'b0010);
    edgeMode = 2'd0;
    for (int f = 2; f <= 10; f++) begin
      frame();
      if (f == 8) begin
        check("bounce_x1", 32'(tlx[1]), 32'd576);
        check("bounce_right1", 32'(seen_hit[1]), 32'b0001);
      end
    end
    check("run10_x0", 32'(tlx[0]), 32'd47);
    check("run10_y0", 32'(tly[0]), 32'd100);

    // Two toggleX edges inside one frame negate vx only once.
    toggle_pulse(1'b0);
    toggle_pulse(1'b0);
    frame();
    frame();

    // Stop mode: fall until Y crosses the bottom.
    edgeMode = 2'd2;
    got_hit = 0;
    for (int k = 0; k < 400 && !got_hit; k++) begin
      frame();
      if (m_hit[0][2]) got_hit = 1;
    end
    check("stop_reached", 32'(got_hit), 32'd1);
    check("stop_y0", 32'(tly[0]), 32'd416);
    check("stop_bottom0", 32'(seen_hit[0][2]), 32'd1);
    frame();
    frame();
    check("stop_hold_y0", 32'(tly[0]), 32'd416);

    // Start together with a frame pulse: re-initialise, no step.
    edgeMode = 2'd0;
    start_pulse(1'b1);
    check("restart_x0", 32'(tlx[0]), 32'd40);
    for (int k = 0; k < 20; k++) frame();

    // Pause with a toggleY in the middle, then resume.
    set_pause(1'b1);
    frame();
    frame();
    toggle_pulse(1'b1);
    frame();
    frame();
    check("pause_y0", 32'(tly[0]), 32'd103);
    set_pause(1'b0);
    frame();
    check("resume_y0", 32'(tly[0]), 32'd102);
    check("resume_mv0", 32'(mv[0]), 32'd1);
    frame();

    // Reset in the middle of running.
    reset = 1'b1;
    m_reset();
    push_all(1'b0);
    cycle();
    drain();
    reset = 1'b0;
    cycle();
    frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_motion_gen.md
Name: sprite_motion_gen

Overview:
Parametrised fixed-point motion generator for one sprite's top-left corner. It is the successor to the single-mode ball/ship mover. It adds:
- configurable frame and sprite geometry, fractional precision and speed saturation
- run-time edge mode (bounce / wrap / stop)
- pause, X and Y toggles, and edge-hit reporting

It sits between the game controller and the sprite's draw/rect block, and updates once per frame on startOfFrame.

Parameters:
FRAC_BITS, 6, fractional bits of internal position/speed (scale 2^FRAC_BITS)
POS_W, 24, signed width of internal position and speed registers
FRAME_W, 640, screen width in pixels
FRAME_H, 480, screen height in pixels
SPRITE_W, 64, sprite width in pixels
SPRITE_H, 64, sprite height in pixels
INITIAL_X, 40, start X in pixels
INITIAL_Y, 100, start Y in pixels
INITIAL_X_SPEED, 50, start X speed (fixed-point units/frame)
INITIAL_Y_SPEED, 0, start Y speed
Y_ACCEL, 1, signed gravity added to Y speed each frame (positive = downward)
MAX_SPEED, 512, speed magnitude saturation limit

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
start  in  1  rising edge loads initial position/speeds and enters RUN
pause  in  1  level; high freezes motion while in RUN
toggleX  in  1  rising edge requests X speed negation
toggleY  in  1  rising edge requests Y speed negation
edgeMode  in  2  0=bounce, 1=wrap, 2=stop, 3=bounce
topLeftX  out  11  integer X = posX >> FRAC_BITS
topLeftY  out  11  integer Y = posY >> FRAC_BITS
moving  out  1  high in RUN
hitEdge  out  4  one-cycle pulse {top,bottom,left,right}

Behaviour:
- One clock, clk. Reset is synchronous, active-high. All state updates on posedge clk.
- Reset values:
  - state=IDLE
  - posX=INITIAL_X<<FRAC_BITS, posY=INITIAL_Y<<FRAC_BITS; topLeftX=INITIAL_X, topLeftY=INITIAL_Y
  - speeds 0, moving=0, hitEdge=0
  - edge-detect registers 0, pending toggles 0
- Bounds per axis: MIN=0, MAXX=(FRAME_W-SPRITE_W)<<FRAC_BITS, MAXY=(FRAME_H-SPRITE_H)<<FRAC_BITS.
- Wrap span per axis: LX=MAXX+(1<<FRAC_BITS), likewise LY.
- States:
  - IDLE: position and speed held. start rising edge → RUN; that cycle reloads initial position/speeds and clears pending toggles.
  - RUN: moving=1. pause high → PAUSE. start rising edge re-initialises (restart).
  - PAUSE: everything frozen and moving=0. pause low → RUN. start rising edge → RUN with re-initialisation.
- Toggle handling:
  - toggleX/Y rising edges set sticky pending flags in any state.
  - Flags are consumed and cleared only at a RUN startOfFrame.
  - Multiple edges within one frame still mean a single negation.
- Frame update, on a startOfFrame cycle in RUN only, combinational then registered:
  1. vy1 = sat(vy + Y_ACCEL); vx1 = vx.
  2. If pendX, vx1 = -vx1. If pendY, vy1 = -vy1.
  3. nx = posX + vx1; ny = posY + vy1.
  4. Edge mode (edgeMode sampled this cycle), per axis:
     - bounce: n<MIN → pos=MIN, v=+|v1|. n>MAX → pos=MAX, v=-|v1|.
     - wrap: n<MIN → pos=n+L. n>MAX → pos=n-L. v unchanged.
     - stop: clamp pos to MIN/MAX, v=0.
     - n==MIN or n==MAX is not a hit.
  5. hitEdge bits are set for each crossing, including wrap crossings. hitEdge is a one-cycle pulse in the cycle after startOfFrame.
- sat() clamps to ±MAX_SPEED. Negation of -MAX_SPEED is safe because MAX_SPEED < 2^(POS_W-1).
- Latency: topLeftX/Y change exactly one cycle after the startOfFrame pulse. Outputs are registered.
- start edge coinciding with startOfFrame: re-initialisation wins and no motion step occurs that frame.
- reset mid-operation: returns to the reset values on the next edge regardless of state.

Optional Feature:
SPRITE_MOTION_FRICTION_EN
- Defined: a 3-bit frame counter counts RUN startOfFrames. Every 8th, |vx| is reduced by 1 before step 2, clamped at 0, sign kept.
- Undefined: no counter and vx is unchanged by time; behaviour is exactly as above.

Test Plan:
- Reset held, then 5 startOfFrame pulses without start → topLeftX=40, topLeftY=100, moving=0, hitEdge=0.
- start, then 10 frames in bounce mode with defaults → posX=2560+500=3060 (topLeftX=47); vy=10, posY=6400+55=6455 (topLeftY=100).
- INITIAL_X=570, bounce: posX 36480+50/frame; frame 8 gives 36880>36864 → topLeftX=576, vx=-50, hitEdge=0001 for one cycle.
- INITIAL_X=0, INITIAL_X_SPEED=-64, edgeMode=1 → next frame posX=-64+36928=36864 (topLeftX=576), hitEdge left bit pulses.
- edgeMode=2 with Y falling past 26624 → topLeftY=416, vy=0 thereafter (until gravity re-accelerates and clamps again), hitEdge bottom bit pulses.
- pause high for 4 frames with a toggleY pulse mid-pause → no position change; on first frame after pause low, vy is negated once and moving returns to 1.
